uart_tx_fifo_ctrl: RTL and testbench

//  Buffered 8N1 UART transmitter: the outbound counterpart of the uart receiver feeding CPU memory load.

---
 rtl/uart_tx_fifo_ctrl_pkg.sv | 15 +
 rtl/uart_tx_fifo_ctrl_byte_fifo.sv | 66 ++++++
 rtl/uart_tx_fifo_ctrl.sv | 135 +++++++++++++
 tb/tb_uart_tx_fifo_ctrl.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_fifo_ctrl_pkg.sv
// Shared types and constants for the buffered UART transmitter.
// The optional even-parity bit is enabled with the UART_TX_PARITY_EN macro.
package uart_tx_fifo_ctrl_pkg;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_PARITY,
        TX_STOP
    } uart_tx_state_e;

    localparam int UART_DATA_BITS = 8;

endpackage

// File: rtl/uart_tx_fifo_ctrl_byte_fifo.sv
// Synchronous byte FIFO: first-word-fall-through read port, registered count/full/empty.
module uart_byte_fifo
    import uart_tx_fifo_ctrl_pkg::*;
#(
    parameter int DEPTH = 16,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic                      clk,
    input  logic                      srst,
    input  logic                      push,
    input  logic [UART_DATA_BITS-1:0] push_data,
    input  logic                      pop,
    output logic [UART_DATA_BITS-1:0] pop_data,
    output logic                      full,
    output logic                      empty,
    output logic [CW-1:0]             count
);

    logic [UART_DATA_BITS-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [CW-1:0] count_reg, count_next;
    logic          full_reg, empty_reg;
    logic          push_ok, pop_ok;

    assign push_ok = push && !full_reg;
    assign pop_ok  = pop && !empty_reg;

    always_comb begin
        count_next = count_reg;
        if (push_ok && !pop_ok)
            count_next = count_reg + CW'(1);
        else if (pop_ok && !push_ok)
            count_next = count_reg - CW'(1);
    end

    // Storage carries no reset so it maps onto distributed/block memory.
    always_ff @(posedge clk) begin
        if (push_ok)
            mem[wr_ptr_reg] <= push_data;
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            full_reg   <= 1'b0;
            empty_reg  <= 1'b1;
        end else begin
            if (push_ok)
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            if (pop_ok)
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            count_reg <= count_next;
            full_reg  <= (count_next == CW'(DEPTH));
            empty_reg <= (count_next == '0);
        end
    end

    assign pop_data = mem[rd_ptr_reg];
    assign full     = full_reg;
    assign empty    = empty_reg;
    assign count    = count_reg;

endmodule

// File: rtl/uart_tx_fifo_ctrl.sv
// Buffered UART transmitter: byte FIFO feeding an 8N1 serialiser (8E1 when UART_TX_PARITY_EN
// is defined). io_tx is registered from the current state, so a frame starts two edges after push.
module uart_tx_fifo_ctrl
    import uart_tx_fifo_ctrl_pkg::*;
#(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD_RATE  = 115_200,
    parameter int FIFO_DEPTH = 16,
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      io_data_valid,
    input  logic [UART_DATA_BITS-1:0] io_data_packet,
    output logic                      io_data_ready,
    output logic                      io_tx,
    output logic                      tx_busy,
    output logic [CNT_W-1:0]          fifo_count
);

    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
    localparam int BAUD_W       = $clog2(CLKS_PER_BIT);

    uart_tx_state_e            state_reg, state_next;
    logic [BAUD_W-1:0]         baud_reg, baud_next;
    logic [2:0]                bit_idx_reg, bit_idx_next;
    logic [UART_DATA_BITS-1:0] shift_reg, shift_next;
    logic                      io_tx_reg, tx_bit;
    logic                      fifo_pop, fifo_full, fifo_empty, bit_done;
    logic [UART_DATA_BITS-1:0] fifo_data;
`ifdef UART_TX_PARITY_EN
    logic                      parity_reg, parity_next;
`endif

    uart_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk       (clk),
        .srst      (reset),
        .push      (io_data_valid),
        .push_data (io_data_packet),
        .pop       (fifo_pop),
        .pop_data  (fifo_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign bit_done = (baud_reg == BAUD_W'(CLKS_PER_BIT - 1));

    always_comb begin
        state_next   = state_reg;
        baud_next    = bit_done ? '0 : baud_reg + BAUD_W'(1);
        bit_idx_next = bit_idx_reg;
        shift_next   = shift_reg;
        fifo_pop     = 1'b0;
        tx_bit       = 1'b1;
`ifdef UART_TX_PARITY_EN
        parity_next  = parity_reg;
`endif
        case (state_reg)
            TX_IDLE: begin
                baud_next = '0;
                if (!fifo_empty) begin
                    fifo_pop   = 1'b1;
                    shift_next = fifo_data;
                    state_next = TX_START;
`ifdef UART_TX_PARITY_EN
                    parity_next = ^fifo_data;
`endif
                end
            end
            TX_START: begin
                tx_bit = 1'b0;
                if (bit_done) begin
                    bit_idx_next = '0;
                    state_next   = TX_DATA;
                end
            end
            TX_DATA: begin
                tx_bit = shift_reg[0];
                if (bit_done) begin
                    shift_next   = shift_reg >> 1;
                    bit_idx_next = bit_idx_reg + 3'd1;
                    if (bit_idx_reg == 3'(UART_DATA_BITS - 1))
`ifdef UART_TX_PARITY_EN
                        state_next = TX_PARITY;
`else
                        state_next = TX_STOP;
`endif
                end
            end
`ifdef UART_TX_PARITY_EN
            TX_PARITY: begin
                tx_bit = parity_reg;
                if (bit_done)
                    state_next = TX_STOP;
            end
`endif
            TX_STOP: begin
                if (bit_done)
                    state_next = TX_IDLE;
            end
            default: begin
                baud_next  = '0;
                state_next = TX_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= TX_IDLE;
            baud_reg    <= '0;
            bit_idx_reg <= '0;
            shift_reg   <= '0;
            io_tx_reg   <= 1'b1;
`ifdef UART_TX_PARITY_EN
            parity_reg  <= 1'b0;
`endif
        end else begin
            state_reg   <= state_next;
            baud_reg    <= baud_next;
            bit_idx_reg <= bit_idx_next;
            shift_reg   <= shift_next;
            io_tx_reg   <= tx_bit;
`ifdef UART_TX_PARITY_EN
            parity_reg  <= parity_next;
`endif
        end
    end

    assign io_tx         = io_tx_reg;
    assign io_data_ready = !fifo_full;
    assign tx_busy       = (state_reg != TX_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_uart_tx_fifo_ctrl.sv
// Directed bench for uart_tx_fifo_ctrl: table of single-byte frames plus back-to-back, FIFO fill
// and mid-frame reset sequences, decoded by a line-level receiver model.
module tb_uart_tx_fifo_ctrl;

    localparam int CLK_FREQ   = 1000;
    localparam int BAUD_RATE  = 100;
    localparam int CPB        = 10;
    localparam int FIFO_DEPTH = 16;
`ifdef UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif
    localparam int FRAME = NB * CPB;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       io_data_valid = 1'b0;
    logic [7:0] io_data_packet = 8'h00;
    logic       io_data_ready, io_tx, tx_busy;
    logic [4:0] fifo_count;

    uart_tx_fifo_ctrl #(
        .CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD_RATE), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .io_data_valid  (io_data_valid),
        .io_data_packet (io_data_packet),
        .io_data_ready  (io_data_ready),
        .io_tx          (io_tx),
        .tx_busy        (tx_busy),
        .fifo_count     (fifo_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end else begin
            $display("ok   %s: 0x%0h (cycle %0d)", name, act, cyc);
        end
    endtask

    // Receiver model: samples io_tx mid-bit on the falling clock edge.
    logic [10:0] rx_line_q[$];
    int          rx_t_q[$];
    bit          mon_active = 0;
    int          mon_cnt = 0;
    int          mon_t = 0;
    logic [10:0] mon_line = '0;

    always @(negedge clk) begin
        if (reset) begin
            mon_active = 0;
        end else if (!mon_active) begin
            if (io_tx == 1'b0) begin
                mon_active = 1;
                mon_cnt    = 0;
                mon_t      = cyc;
                mon_line   = '0;
            end
        end else begin
            mon_cnt++;
            if (mon_cnt % CPB == CPB / 2)
                mon_line[mon_cnt / CPB] = io_tx;
            if (mon_cnt == FRAME - 1) begin
                rx_line_q.push_back(mon_line);
                rx_t_q.push_back(mon_t);
                mon_active = 0;
            end
        end
    end

    task automatic push_byte(input logic [7:0] b, output int k);
        @(negedge clk);
        io_data_valid  = 1'b1;
        io_data_packet = b;
        k = cyc + 1;
        @(negedge clk);
        io_data_valid = 1'b0;
    endtask

    task automatic wait_rx(input int n, input int budget);
        int t = 0;
        while (rx_line_q.size() < n && t < budget) begin
            @(negedge clk);
            t++;
        end
        if (rx_line_q.size() < n)
            check("rx_frame_timeout", rx_line_q.size(), n);
    endtask

    function automatic int rx_byte(input int i);
        logic [10:0] l;
        if (i >= rx_line_q.size()) return -1;
        l = rx_line_q[i];
        return int'(l[8:1]);
    endfunction

    typedef struct {
        logic [7:0]  data;
        logic [10:0] exp_line;   // {[parity,] stop ... } as sampled: bit0 = start
    } vec_t;

    vec_t vecs[$];

    initial begin
        int k, k2;

`ifdef UART_TX_PARITY_EN
        vecs.push_back('{8'h07, 11'b1_1_00000111_0});
        vecs.push_back('{8'h03, 11'b1_0_00000011_0});
        vecs.push_back('{8'h55, 11'b1_0_01010101_0});
`else
        vecs.push_back('{8'h55, 11'b0_1_01010101_0});
        vecs.push_back('{8'hA3, 11'b0_1_10100011_0});
        vecs.push_back('{8'h00, 11'b0_1_00000000_0});
        vecs.push_back('{8'hFF, 11'b0_1_11111111_0});
        vecs.push_back('{8'h80, 11'b0_1_10000000_0});
`endif

        // Reset held for three cycles
        repeat (3) @(negedge clk);
        check("rst_io_tx", io_tx, 1);
        check("rst_tx_busy", tx_busy, 0);
        check("rst_ready", io_data_ready, 1);
        check("rst_count", fifo_count, 0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Table: single frames, latency and frame length
        foreach (vecs[i]) begin
            rx_line_q.delete();
            rx_t_q.delete();
            push_byte(vecs[i].data, k);
            check($sformatf("v%0d_count_after_push", i), fifo_count, 1);
            check($sformatf("v%0d_busy_after_push", i), tx_busy, 1);
            wait_rx(1, FRAME + 20);
            if (rx_line_q.size() > 0) begin
                check($sformatf("v%0d_line", i), rx_line_q[0], vecs[i].exp_line);
                check($sformatf("v%0d_start_latency", i), rx_t_q[0] - k, 2);
            end
            while (cyc < k + 2 + FRAME) @(negedge clk);
            check($sformatf("v%0d_idle_tx", i), io_tx, 1);
            check($sformatf("v%0d_idle_busy", i), tx_busy, 0);
        end

        // Back-to-back 0xA3, 0x0F
        rx_line_q.delete();
        rx_t_q.delete();
        @(negedge clk);
        io_data_valid = 1'b1;
        io_data_packet = 8'hA3;
        @(negedge clk);
        io_data_packet = 8'h0F;
        @(negedge clk);
        io_data_valid = 1'b0;
        check("b2b_count_push_pop", fifo_count, 1);
        wait_rx(2, 2 * FRAME + 40);
        check("b2b_byte0", rx_byte(0), 8'hA3);
        check("b2b_byte1", rx_byte(1), 8'h0F);
        if (rx_t_q.size() >= 2)
            check("b2b_gap", rx_t_q[1] - rx_t_q[0], FRAME + 1);
        repeat (10) @(negedge clk);

        // Fill: one byte in flight, then 17 pushes into a 16-deep FIFO
        rx_line_q.delete();
        rx_t_q.delete();
        push_byte(8'hC3, k);
        repeat (5) @(negedge clk);
        for (int i = 0; i < 17; i++) begin
            if (i == 16) begin
                check("fill_ready_full", io_data_ready, 0);
                check("fill_count_full", fifo_count, 16);
            end
            io_data_valid = 1'b1;
            io_data_packet = 8'(i);
            @(negedge clk);
        end
        io_data_valid = 1'b0;
        check("fill_count_after_drop", fifo_count, 16);
        wait_rx(17, 18 * FRAME + 100);
        check("fill_first", rx_byte(0), 8'hC3);
        for (int i = 0; i < 16; i++)
            check($sformatf("fill_byte%0d", i), rx_byte(i + 1), i);
        repeat (FRAME + 20) @(negedge clk);
        check("fill_no_dropped_frame", rx_line_q.size(), 17);
        check("fill_drained_count", fifo_count, 0);
        check("fill_drained_ready", io_data_ready, 1);

        // Reset during DATA bit 3 of 0xFF with four bytes queued
        rx_line_q.delete();
        rx_t_q.delete();
        @(negedge clk);
        k = cyc + 1;
        io_data_valid = 1'b1;
        io_data_packet = 8'hFF;
        @(negedge clk);
        io_data_packet = 8'h11;
        @(negedge clk);
        io_data_packet = 8'h22;
        @(negedge clk);
        io_data_packet = 8'h33;
        @(negedge clk);
        io_data_packet = 8'h44;
        @(negedge clk);
        io_data_valid = 1'b0;
        check("rstmid_count_queued", fifo_count, 4);
        while (cyc < k + 2 + 4 * CPB + CPB / 2) @(negedge clk);
        check("rstmid_bit3_high", io_tx, 1);
        check("rstmid_busy_before", tx_busy, 1);
        reset = 1'b1;
        @(negedge clk);
        check("rstmid_io_tx", io_tx, 1);
        check("rstmid_count", fifo_count, 0);
        check("rstmid_busy", tx_busy, 0);
        reset = 1'b0;
        k2 = 0;
        while (k2 < 2 * FRAME) begin
            @(negedge clk);
            if (io_tx !== 1'b1) break;
            k2++;
        end
        check("rstmid_line_quiet", k2, 2 * FRAME);
        check("rstmid_no_frames", rx_line_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "timeout");
    end

endmodule
